// File: rtl/aes_buffered_round_pkg.sv
// Shared AES-128 definitions for the unrolled round pipeline.
//   - state_t / roundKey_t : 128-bit state and round key, byte i at [127-8i -: 8],
//                            byte i sits at row i%4, column i/4 (column-major).
//   - NUM_ROUNDS           : round count of AES-128.
//   - TRUE / FALSE         : single-bit parameter constants.
//   - SBOX / INV_SBOX      : 256-entry constant substitution tables.
//   - xtime / gf_mul       : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 (0x11B).
//   - round step helpers   : (Inv)SubBytes, (Inv)ShiftRows, (Inv)MixColumns.
package aes_buffered_round_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] roundKey_t;

  localparam int NUM_ROUNDS = 10;

  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8); the carry out of bit 7 folds back as 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply (shift-and-add). Used with constant
  // coefficients, so it reduces to a small XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return r;
  endfunction

  // Row r rotates left by r: out(r,c) = in(r,(c+r)%4).
  function automatic state_t shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  // Row r rotates right by r: out(r,c) = in(r,(c-r)%4).
  function automatic state_t inv_shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+4-row)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  // One column times the {02 03 01 01} circulant; a0 is the row-0 byte.
  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // One column times the {0E 0B 0D 09} circulant.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// Combinational AES-128 round function.
//   INVERSE     : 0 = cipher round, 1 = InvCipher round (FIPS-197 order).
//   FINAL_ROUND : 1 drops the (Inv)MixColumns step.
// Ports:
//   state_i : round input state
//   key_i   : round key
//   state_o : round result (unregistered)
module aes_round_comb
  import aes_buffered_round_pkg::*;
#(
  parameter bit INVERSE     = FALSE,
  parameter bit FINAL_ROUND = FALSE
) (
  input  state_t    state_i,
  input  roundKey_t key_i,
  output state_t    state_o
);

  state_t pre_mix;

  if (!INVERSE) begin : g_fwd
    // SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
    assign pre_mix = shift_rows(sub_bytes(state_i));
    if (FINAL_ROUND) begin : g_final
      assign state_o = pre_mix ^ key_i;
    end else begin : g_mid
      assign state_o = mix_columns(pre_mix) ^ key_i;
    end
  end else begin : g_inv
    // InvShiftRows -> InvSubBytes -> AddRoundKey -> [InvMixColumns];
    // the key is added before the mix, unlike the forward round.
    assign pre_mix = inv_sub_bytes(inv_shift_rows(state_i)) ^ key_i;
    if (FINAL_ROUND) begin : g_final
      assign state_o = pre_mix;
    end else begin : g_mid
      assign state_o = inv_mix_columns(pre_mix);
    end
  end

endmodule

// File: rtl/aes_buffered_round.sv
// One registered AES-128 round: one pipeline stage of latency 1.
// Parameters:
//   ROUND      : round index 1..NUM_ROUNDS; ROUND == NUM_ROUNDS is the final round.
//   NUM_ROUNDS : total rounds (package default 10).
//   INVERSE    : 0 = cipher round, 1 = inverse cipher round.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset, clears out, wins over enable
//   enable : load enable for the output register
//   in     : round input state
//   key    : round key
//   out    : registered round result
// Flow control: there is no valid/ready handshake. Every cycle with enable
// high captures f(in, key); with enable low the register holds. A new input
// may be presented every cycle.
module aes_buffered_round #(
  parameter int ROUND      = 1,
  parameter int NUM_ROUNDS = aes_buffered_round_pkg::NUM_ROUNDS,
  parameter int INVERSE    = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  aes_buffered_round_pkg::state_t    in,
  input  aes_buffered_round_pkg::roundKey_t key,
  output aes_buffered_round_pkg::state_t    out
);

  localparam bit IS_FINAL = (ROUND == NUM_ROUNDS) ? aes_buffered_round_pkg::TRUE
                                                  : aes_buffered_round_pkg::FALSE;
  localparam bit IS_INV   = (INVERSE != 0) ? aes_buffered_round_pkg::TRUE
                                           : aes_buffered_round_pkg::FALSE;

  aes_buffered_round_pkg::state_t round_res;
  aes_buffered_round_pkg::state_t out_d;
  aes_buffered_round_pkg::state_t out_q;

  aes_round_comb #(
    .INVERSE    (IS_INV),
    .FINAL_ROUND(IS_FINAL)
  ) u_comb (
    .state_i(in),
    .key_i  (key),
    .state_o(round_res)
  );

  always_comb begin
    out_d = out_q;
    if (enable) out_d = round_res;
  end

  always_ff @(posedge clock) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_aes_buffered_round.sv
// Directed bench for aes_buffered_round: four instances cover forward/inverse
// and middle/final rounds, driven from one linear initial block.
module tb_aes_buffered_round;
  import aes_buffered_round_pkg::*;

  // FIPS-197 Appendix C.1 (AES-128) values.
  localparam state_t R1_START = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam state_t R1_KEY   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam state_t R2_START = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam state_t R2_KEY   = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
  localparam state_t R3_START = 128'h4915598f55e5d7a0daca94fa1f0a63f7;
  localparam state_t R3_KEY   = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
  localparam state_t R4_START = 128'hfa636a2825b339c940668a3157244d17;

  localparam state_t F10_IN   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam state_t F10_KEY  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam state_t F10_OUT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam state_t I1_IN    = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam state_t I1_KEY   = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam state_t I1_OUT   = 128'h54d990a16ba09ab596bbf40ea111702f;

  localparam state_t I10_IN   = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam state_t I10_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t I10_OUT  = 128'h00112233445566778899aabbccddeeff;

  logic clock;
  logic reset;
  logic enable;
  state_t in_f1, in_f10, in_i1, in_i10;
  state_t key_f1, key_f10, key_i1, key_i10;
  state_t out_f1, out_f10, out_i1, out_i10;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  aes_buffered_round #(.ROUND(1), .INVERSE(0)) u_fwd1 (
    .clock(clock), .reset(reset), .enable(enable), .in(in_f1), .key(key_f1), .out(out_f1));
  aes_buffered_round #(.ROUND(10), .INVERSE(0)) u_fwd10 (
    .clock(clock), .reset(reset), .enable(enable), .in(in_f10), .key(key_f10), .out(out_f10));
  aes_buffered_round #(.ROUND(1), .INVERSE(1)) u_inv1 (
    .clock(clock), .reset(reset), .enable(enable), .in(in_i1), .key(key_i1), .out(out_i1));
  aes_buffered_round #(.ROUND(10), .INVERSE(1)) u_inv10 (
    .clock(clock), .reset(reset), .enable(enable), .in(in_i10), .key(key_i10), .out(out_i10));

  // ---------------- driver tasks ----------------
  function automatic state_t rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_inputs();
    in_f1  = rand128(); key_f1  = rand128();
    in_f10 = rand128(); key_f10 = rand128();
    in_i1  = rand128(); key_i1  = rand128();
    in_i10 = rand128(); key_i10 = rand128();
  endtask

  task automatic drive_directed();
    in_f1  = R1_START; key_f1  = R1_KEY;
    in_f10 = F10_IN;   key_f10 = F10_KEY;
    in_i1  = I1_IN;    key_i1  = I1_KEY;
    in_i10 = I10_IN;   key_i10 = I10_KEY;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input state_t observed, input state_t expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input state_t e_f1, input state_t e_f10,
                           input state_t e_i1, input state_t e_i10);
    check({tag, "_fwd1"},  out_f1,  e_f1);
    check({tag, "_fwd10"}, out_f10, e_f10);
    check({tag, "_inv1"},  out_i1,  e_i1);
    check({tag, "_inv10"}, out_i10, e_i10);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    randomize_inputs();

    // Reset held two cycles with arbitrary inputs.
    step();
    check_all("reset_c1", '0, '0, '0, '0);
    randomize_inputs();
    step();
    check_all("reset_c2", '0, '0, '0, '0);

    // Known-answer vectors, one edge of latency.
    reset = 1'b0;
    drive_directed();
    step();
    check_all("kat", R2_START, F10_OUT, I1_OUT, I10_OUT);

    // enable low: inputs change, outputs hold.
    enable = 1'b0;
    randomize_inputs();
    step();
    check_all("hold_c1", R2_START, F10_OUT, I1_OUT, I10_OUT);
    randomize_inputs();
    step();
    check("hold_c2_fwd1", out_f1, R2_START);

    // Back-to-back stream through the middle-round forward stage.
    enable = 1'b1;
    in_f1 = R1_START; key_f1 = R1_KEY;
    step();
    check("stream_r1", out_f1, R2_START);
    in_f1 = R2_START; key_f1 = R2_KEY;
    step();
    check("stream_r2", out_f1, R3_START);
    in_f1 = R3_START; key_f1 = R3_KEY;
    step();
    check("stream_r3", out_f1, R4_START);

    // Reset mid-stream clears everything on the next edge.
    drive_directed();
    reset = 1'b1;
    step();
    check_all("midrst", '0, '0, '0, '0);

    // First valid result one edge after reset drops.
    reset = 1'b0;
    step();
    check_all("post_rst", R2_START, F10_OUT, I1_OUT, I10_OUT);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
